// File: rtl/axi4_rd_arbiter.sv
// axi4_rd_arbiter
// Round-robin arbiter that shares one AXI4 AR/R read port of a slave among
// NUM_MASTERS read masters. Exactly one read burst is in flight at a time.
// The grant is taken in IDLE, held through the AR handshake (ADDR) and
// released after the RLAST beat (DATA). The write channels are not involved.
//
// Optional feature macro: AXI_ARB_TIMEOUT_EN
//   When defined, a 16-bit watchdog runs during DATA. If no R handshake is
//   seen for TIMEOUT_CYCLES cycles, the arbiter ends the burst on the master
//   side with a single SLVERR/RLAST beat and returns to IDLE.
//   When undefined, DATA waits for S_RLAST for as long as it takes.

module axi4_rd_arbiter #(
  parameter int DATA_WIDTH     = 1024,
  parameter int ADDR_WIDTH     = $clog2(1024 * DATA_WIDTH),
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  // master-side AR channels (flattened, master i at slice i)
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] M_ARADDR,
  input  logic [NUM_MASTERS*2-1:0]          M_ARBURST,
  input  logic [NUM_MASTERS*8-1:0]          M_ARLEN,
  input  logic [NUM_MASTERS*3-1:0]          M_ARSIZE,
  input  logic [NUM_MASTERS-1:0]            M_ARVALID,
  output logic [NUM_MASTERS-1:0]            M_ARREADY,
  // master-side R channels (payload broadcast, valid per master)
  output logic [DATA_WIDTH-1:0]             M_RDATA,
  output logic [1:0]                        M_RRESP,
  output logic                              M_RLAST,
  output logic [NUM_MASTERS-1:0]            M_RVALID,
  input  logic [NUM_MASTERS-1:0]            M_RREADY,
  // slave-side AR channel
  output logic [ADDR_WIDTH-1:0]             S_ARADDR,
  output logic [1:0]                        S_ARBURST,
  output logic [7:0]                        S_ARLEN,
  output logic [2:0]                        S_ARSIZE,
  output logic                              S_ARVALID,
  input  logic                              S_ARREADY,
  // slave-side R channel
  input  logic [DATA_WIDTH-1:0]             S_RDATA,
  input  logic [1:0]                        S_RRESP,
  input  logic                              S_RLAST,
  input  logic                              S_RVALID,
  output logic                              S_RREADY
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  typedef logic [IDX_W-1:0] idx_t;

  // After reset the pointer sits on the last master so master 0 wins first.
  localparam idx_t LAST_RST = idx_t'(NUM_MASTERS - 1);

  // Elaboration-time sanity checks on the configuration.
  if (NUM_MASTERS < 2 || NUM_MASTERS > 8) begin : g_bad_num_masters
    $error("axi4_rd_arbiter: NUM_MASTERS must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("axi4_rd_arbiter: TIMEOUT_CYCLES must fit the 16-bit watchdog");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
`ifdef AXI_ARB_TIMEOUT_EN
    ,
    ST_TOUT = 2'd3
`endif
  } state_t;

  state_t state_q, state_d;
  idx_t   gnt_q, gnt_d;
  idx_t   last_q, last_d;

  // Round-robin pick: first requester strictly after 'last', wrapping.
  // Scanned from the far end so the nearest candidate overwrites the rest.
  function automatic idx_t rr_pick(input logic [NUM_MASTERS-1:0] req,
                                   input idx_t                   last);
    idx_t r;
    int   idx;
    r = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_MASTERS;
      if (req[idx_t'(idx)]) begin
        r = idx_t'(idx);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Granted master's AR payload and handshake inputs.
  logic [ADDR_WIDTH-1:0] sel_araddr_s;
  logic [1:0]            sel_arburst_s;
  logic [7:0]            sel_arlen_s;
  logic [2:0]            sel_arsize_s;
  logic                  gnt_arvalid_s;
  logic                  gnt_rready_s;
  logic                  req_any_s;
  idx_t                  pick_s;
  logic                  ar_hs_s;
  logic                  r_hs_s;
  logic                  r_done_s;

  assign sel_araddr_s  = M_ARADDR[int'(gnt_q)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_arburst_s = M_ARBURST[int'(gnt_q)*2 +: 2];
  assign sel_arlen_s   = M_ARLEN[int'(gnt_q)*8 +: 8];
  assign sel_arsize_s  = M_ARSIZE[int'(gnt_q)*3 +: 3];
  assign gnt_arvalid_s = M_ARVALID[gnt_q];
  assign gnt_rready_s  = M_RREADY[gnt_q];
  assign req_any_s     = |M_ARVALID;
  assign pick_s        = rr_pick(M_ARVALID, last_q);

  assign ar_hs_s  = (state_q == ST_ADDR) && gnt_arvalid_s && S_ARREADY;
  assign r_hs_s   = (state_q == ST_DATA) && S_RVALID && gnt_rready_s;
  assign r_done_s = r_hs_s && S_RLAST;

`ifdef AXI_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] cnt_q, cnt_d;
  logic        tmo_hit_s;

  // Watchdog fires on the cycle the count would reach the limit.
  assign tmo_hit_s = (state_q == ST_DATA) && !r_hs_s && ((cnt_q + 16'd1) == TMO_LIMIT);

  // Watchdog next value: cleared entering DATA and on each R beat.
  always_comb begin
    cnt_d = cnt_q;
    if (ar_hs_s) begin
      cnt_d = 16'd0;
    end else if (state_q == ST_DATA) begin
      if (r_hs_s) begin
        cnt_d = 16'd0;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // State, grant and round-robin pointer registers.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      last_q  <= LAST_RST;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic: grant in IDLE, AR handshake in ADDR, RLAST ends DATA.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (req_any_s) begin
          gnt_d   = pick_s;
          state_d = ST_ADDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (ar_hs_s) begin
          state_d = ST_DATA;
        end else if (!gnt_arvalid_s) begin
          // Master withdrew its request: drop the grant, pointer untouched.
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (r_done_s) begin
          last_d  = gnt_q;
          state_d = ST_IDLE;
        end else begin
`ifdef AXI_ARB_TIMEOUT_EN
          if (tmo_hit_s) begin
            state_d = ST_TOUT;
          end else begin
            state_d = ST_DATA;
          end
`else
          state_d = ST_DATA;
`endif
        end
      end
`ifdef AXI_ARB_TIMEOUT_EN
      ST_TOUT: begin
        if (gnt_rready_s) begin
          last_d  = gnt_q;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_TOUT;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Channel muxing: AR routed only in ADDR, R routed only in DATA.
  always_comb begin
    S_ARADDR  = '0;
    S_ARBURST = 2'b00;
    S_ARLEN   = 8'd0;
    S_ARSIZE  = 3'd0;
    S_ARVALID = 1'b0;
    M_ARREADY = '0;
    M_RDATA   = '0;
    M_RRESP   = 2'b00;
    M_RLAST   = 1'b0;
    M_RVALID  = '0;
    S_RREADY  = 1'b0;
    case (state_q)
      ST_ADDR: begin
        S_ARADDR         = sel_araddr_s;
        S_ARBURST        = sel_arburst_s;
        S_ARLEN          = sel_arlen_s;
        S_ARSIZE         = sel_arsize_s;
        S_ARVALID        = gnt_arvalid_s;
        M_ARREADY[gnt_q] = S_ARREADY;
      end
      ST_DATA: begin
        M_RDATA         = S_RDATA;
        M_RRESP         = S_RRESP;
        M_RLAST         = S_RLAST;
        M_RVALID[gnt_q] = S_RVALID;
        S_RREADY        = gnt_rready_s;
      end
`ifdef AXI_ARB_TIMEOUT_EN
      ST_TOUT: begin
        // Synthetic error beat; the slave is not acknowledged.
        M_RRESP         = 2'b10;
        M_RLAST         = 1'b1;
        M_RVALID[gnt_q] = 1'b1;
      end
`endif
      default: begin
        S_ARVALID = 1'b0;
      end
    endcase
  end

endmodule
